quickq_cmd_frontend: RTL and testbench

- Request front-end directly upstream of the QuickQ control FSM.
- Buffers enqueue/dequeue commands in a small FIFO and issues them one at a time as single-cycle `enq`/`deq` pulses with the key.
- Waits for `ctl_done`, tracks queue occupancy, and returns dequeued keys on a valid/ready response port.
- Rejects enqueues to a full queue and answers dequeues from an empty queue without disturbing the control FSM.

---
 rtl/quickq_cmd_frontend.sv | 208 ++++++++++++++++++++
 tb/tb_quickq_cmd_frontend.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quickq_cmd_frontend.sv
// rtl/quickq_cmd_frontend.sv - command FIFO and one-at-a-time dispatcher in front of the QuickQ control FSM
//
// Optional build macro: QQ_FRONTEND_STATS_EN adds 16-bit saturating counters
// stat_enq, stat_deq and stat_drop. Without it those ports do not exist.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/ready/op/key    command input (op 0 = enqueue, 1 = dequeue)
//   enq, deq, key_out         single-cycle command pulses and key to the control FSM
//   ctl_done, ctl_key         control FSM completion and dequeued key
//   rsp_valid/ready/key/empty dequeue response (all-ones key when queue was empty)
//   q_count, q_full, q_empty  keys currently held by QuickQ
//   err_full                  one-cycle pulse when an enqueue is dropped on a full queue
module quickq_cmd_frontend #(
    parameter int KEY_W      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CAPACITY   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_op,
    input  logic [KEY_W-1:0]               req_key,
    output logic                           enq,
    output logic                           deq,
    output logic [KEY_W-1:0]               key_out,
    input  logic                           ctl_done,
    input  logic [KEY_W-1:0]               ctl_key,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [KEY_W-1:0]               rsp_key,
    output logic                           rsp_empty,
    output logic [$clog2(CAPACITY+1)-1:0]  q_count,
    output logic                           q_full,
    output logic                           q_empty,
    output logic                           err_full
`ifdef QQ_FRONTEND_STATS_EN
    ,
    output logic [15:0]                    stat_enq,
    output logic [15:0]                    stat_deq,
    output logic [15:0]                    stat_drop
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CAPACITY+1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t state, next_state;

    // Command FIFO: each entry is {op, key}
    logic [KEY_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      fifo_cnt;
    logic             fifo_full, fifo_empty;
    logic             push, pop;

    // Current command register
    logic             cmd_op;
    logic [KEY_W-1:0] cmd_key;

    // FSM side effects decided combinationally
    logic             ld_rsp_empty, ld_rsp_done, cnt_inc, cnt_dec;

    assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign req_ready  = !fifo_full;
    assign push       = req_valid && req_ready;

    assign q_full    = (q_count == CW'(CAPACITY));
    assign q_empty   = (q_count == '0);
    assign key_out   = cmd_key;
    assign rsp_valid = (state == S_RESPOND);

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {req_op, req_key};
    end

    always_comb begin
        next_state   = state;
        pop          = 1'b0;
        enq          = 1'b0;
        deq          = 1'b0;
        err_full     = 1'b0;
        ld_rsp_empty = 1'b0;
        ld_rsp_done  = 1'b0;
        cnt_inc      = 1'b0;
        cnt_dec      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (!cmd_op) begin
                    if (q_full) begin
                        err_full   = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        enq        = 1'b1;
                        next_state = S_WAIT;
                    end
                end else begin
                    // Empty dequeue is answered locally; the control FSM never sees it
                    if (q_empty) begin
                        ld_rsp_empty = 1'b1;
                        next_state   = S_RESPOND;
                    end else begin
                        deq        = 1'b1;
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ctl_done) begin
                    if (!cmd_op) begin
                        cnt_inc    = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        cnt_dec     = 1'b1;
                        ld_rsp_done = 1'b1;
                        next_state  = S_RESPOND;
                    end
                end
            end
            S_RESPOND: begin
                if (rsp_ready)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_op    <= 1'b0;
            cmd_key   <= '0;
            rsp_key   <= '0;
            rsp_empty <= 1'b0;
            q_count   <= '0;
        end else begin
            state <= next_state;
            if (pop)
                {cmd_op, cmd_key} <= fifo_mem[rd_ptr];
            if (ld_rsp_empty) begin
                rsp_key   <= '1;
                rsp_empty <= 1'b1;
            end else if (ld_rsp_done) begin
                rsp_key   <= ctl_key;
                rsp_empty <= 1'b0;
            end
            // Dispatch checks already prevent over/underflow; the guards keep it saturating regardless
            if (cnt_inc && !q_full)
                q_count <= q_count + CW'(1);
            else if (cnt_dec && !q_empty)
                q_count <= q_count - CW'(1);
        end
    end

`ifdef QQ_FRONTEND_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_enq  <= '0;
            stat_deq  <= '0;
            stat_drop <= '0;
        end else begin
            if (cnt_inc && stat_enq != 16'hFFFF)
                stat_enq <= stat_enq + 16'd1;
            if ((ld_rsp_done || ld_rsp_empty) && stat_deq != 16'hFFFF)
                stat_deq <= stat_deq + 16'd1;
            if (err_full && stat_drop != 16'hFFFF)
                stat_drop <= stat_drop + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_quickq_cmd_frontend.sv
// tb/tb_quickq_cmd_frontend.sv - self-checking bench for quickq_cmd_frontend
module tb_quickq_cmd_frontend;

    localparam int KEY_W      = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int CAPACITY   = 16;
    localparam int CW         = $clog2(CAPACITY+1);
    localparam logic [KEY_W-1:0] ONES = '1;

    localparam int K_ENQ   = 0;
    localparam int K_DEQ   = 1;
    localparam int K_EMPTY = 2;
    localparam int K_ERR   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_op = 1'b0;
    logic [KEY_W-1:0] req_key = '0;
    logic             enq, deq;
    logic [KEY_W-1:0] key_out;
    logic             ctl_done = 1'b0;
    logic [KEY_W-1:0] ctl_key = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [KEY_W-1:0] rsp_key;
    logic             rsp_empty;
    logic [CW-1:0]    q_count;
    logic             q_full, q_empty, err_full;
`ifdef QQ_FRONTEND_STATS_EN
    logic [15:0]      stat_enq, stat_deq, stat_drop;
`endif

    quickq_cmd_frontend #(
        .KEY_W(KEY_W), .FIFO_DEPTH(FIFO_DEPTH), .CAPACITY(CAPACITY)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
        .enq(enq), .deq(deq), .key_out(key_out),
        .ctl_done(ctl_done), .ctl_key(ctl_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_key(rsp_key), .rsp_empty(rsp_empty),
        .q_count(q_count), .q_full(q_full), .q_empty(q_empty), .err_full(err_full)
`ifdef QQ_FRONTEND_STATS_EN
        , .stat_enq(stat_enq), .stat_deq(stat_deq), .stat_drop(stat_drop)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic             op;
        logic [KEY_W-1:0] key;
        logic [KEY_W-1:0] ctl_key;
        int               kind;
        logic [KEY_W-1:0] exp_rsp;
        int               exp_count;
        int               stall;
    } vec_t;

    typedef struct {
        logic             op;
        logic [KEY_W-1:0] key;
    } cmd_t;

    typedef struct {
        logic [KEY_W-1:0] key;
        logic             empty;
    } rsp_t;

    vec_t tbl[8];

    // Reference model state for the randomized run
    cmd_t             cmds[$];
    rsp_t             exp_rsp[$];
    logic [KEY_W-1:0] store[$];
    cmd_t             c;
    rsp_t             cur;
    logic             outstanding, pend_op, rsp_active, gen;
    logic [KEY_W-1:0] pend_key;
    int               timer, idx, n, seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1; req_valid = 1'b0; ctl_done = 1'b0; rsp_ready = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v);
        int k;
        int s;
        req_valid = 1'b1; req_op = v.op; req_key = v.key;
        tick;
        req_valid = 1'b0;
        k = 0;
        while (!(enq || deq || err_full || rsp_valid) && k < 20) begin
            tick;
            k++;
        end
        if (k == 20) begin
            check("cmd_timeout", 1, 0);
        end else begin
            s = enq ? K_ENQ : deq ? K_DEQ : rsp_valid ? K_EMPTY : K_ERR;
            check("cmd_kind", s, v.kind);
            if (s == K_ENQ || s == K_DEQ) begin
                if (s == K_ENQ) check("enq_key", key_out, v.key);
                repeat (2) tick;
                check("key_hold", key_out, v.key);
                ctl_done = 1'b1; ctl_key = v.ctl_key;
                tick;
                ctl_done = 1'b0;
            end
            if (s == K_DEQ || s == K_EMPTY) begin
                for (int i = 0; i < v.stall; i++) begin
                    check("rsp_valid_held", rsp_valid, 1);
                    check("rsp_key_held", rsp_key, v.exp_rsp);
                    check("rsp_empty_held", rsp_empty, s == K_EMPTY);
                    tick;
                end
                check("rsp_valid", rsp_valid, 1);
                check("rsp_key", rsp_key, v.exp_rsp);
                check("rsp_empty", rsp_empty, s == K_EMPTY);
                rsp_ready = 1'b1;
                tick;
                rsp_ready = 1'b0;
                check("rsp_done", rsp_valid, 0);
            end else if (s == K_ERR) begin
                tick;
                check("err_one_cycle", err_full, 0);
            end else begin
                check("enq_no_rsp", rsp_valid, 0);
            end
        end
        check("q_count_after", q_count, v.exp_count);
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h0,        32'h0,        K_EMPTY, ONES,         0, 0};
        tbl[1] = '{1'b0, 32'h30,       32'h0,        K_ENQ,   32'h0,        1, 0};
        tbl[2] = '{1'b0, 32'h20,       32'h0,        K_ENQ,   32'h0,        2, 0};
        tbl[3] = '{1'b1, 32'h0,        32'h20,       K_DEQ,   32'h20,       1, 4};
        tbl[4] = '{1'b0, 32'hFFFFFFFE, 32'h0,        K_ENQ,   32'h0,        2, 0};
        tbl[5] = '{1'b1, 32'h0,        32'h30,       K_DEQ,   32'h30,       1, 1};
        tbl[6] = '{1'b1, 32'h0,        32'hFFFFFFFE, K_DEQ,   32'hFFFFFFFE, 0, 0};
        tbl[7] = '{1'b1, 32'h0,        32'h0,        K_EMPTY, ONES,         0, 2};

        // Reset state
        do_reset;
        check("rst_enq", enq, 0);
        check("rst_deq", deq, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_empty", rsp_empty, 0);
        check("rst_err_full", err_full, 0);
        check("rst_key_out", key_out, 0);
        check("rst_rsp_key", rsp_key, 0);
        check("rst_q_count", q_count, 0);
        check("rst_q_empty", q_empty, 1);
        check("rst_q_full", q_full, 0);
        check("rst_req_ready", req_ready, 1);

        // Latency: pulse exactly two cycles after the handshake, one cycle wide
        req_valid = 1'b1; req_op = 1'b0; req_key = 32'h10;
        tick;
        req_valid = 1'b0;
        check("lat_c1_enq", enq, 0);
        tick;
        check("lat_c2_enq", enq, 1);
        check("lat_c2_key", key_out, 32'h10);
        tick;
        check("lat_c3_enq", enq, 0);
        repeat (2) tick;
        ctl_done = 1'b1;
        tick;
        ctl_done = 1'b0;
        check("lat_q_count", q_count, 1);
        check("lat_no_rsp", rsp_valid, 0);

        // Table of single commands
        do_reset;
        for (int i = 0; i < 8; i++) run_cmd(tbl[i]);

        // Fill to capacity, then an enqueue on a full queue is dropped
        do_reset;
        for (int i = 0; i < CAPACITY; i++)
            run_cmd('{1'b0, 32'(i + 1), 32'h0, K_ENQ, 32'h0, i + 1, 0});
        check("fill_q_full", q_full, 1);
        run_cmd('{1'b0, 32'h55, 32'h0, K_ERR, 32'h0, CAPACITY, 0});

        // Back-pressure: one command in flight, four queued, then FIFO full
        do_reset;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", req_ready, 1);
            req_valid = 1'b1; req_op = 1'b0; req_key = 32'(32'h40 + i);
            tick;
            if (i == 1) begin
                check("bp_first_enq", enq, 1);
                check("bp_first_key", key_out, 32'h40);
            end
        end
        req_valid = 1'b0;
        check("bp_full", req_ready, 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                n = 0;
                while (!enq && n < 20) begin tick; n++; end
                check("bp_enq_seen", enq, 1);
            end
            check("bp_order", key_out, 32'(32'h40 + i));
            tick;
            ctl_done = 1'b1;
            tick;
            ctl_done = 1'b0;
        end
        check("bp_q_count", q_count, 5);
        check("bp_ready_back", req_ready, 1);

        // Reset while waiting for the control FSM
        do_reset;
        req_valid = 1'b1; req_op = 1'b0; req_key = 32'h77;
        tick;
        req_valid = 1'b0;
        tick;
        check("rw_enq", enq, 1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ctl_done = 1'b1;
        tick;
        ctl_done = 1'b0;
        tick;
        check("rw_q_count", q_count, 0);
        check("rw_rsp_valid", rsp_valid, 0);
        check("rw_req_ready", req_ready, 1);
        check("rw_idle_enq", enq, 0);
        run_cmd('{1'b0, 32'h78, 32'h0, K_ENQ, 32'h0, 1, 0});

        // Randomized traffic against a key-store reference model
        do_reset;
        outstanding = 1'b0; rsp_active = 1'b0; timer = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick;
            check("r_q_count", q_count, store.size());
            check("r_q_full", q_full, store.size() == CAPACITY);
            check("r_q_empty", q_empty, store.size() == 0);
            if (enq || deq || err_full) begin
                if (cmds.size() == 0) begin
                    check("r_unexpected_issue", 1, 0);
                end else begin
                    c = cmds.pop_front();
                    if (enq) begin
                        check("r_enq_op", c.op, 0);
                        check("r_enq_key", key_out, c.key);
                        check("r_enq_room", store.size() < CAPACITY, 1);
                    end else if (deq) begin
                        check("r_deq_op", c.op, 1);
                        check("r_deq_nonempty", store.size() > 0, 1);
                    end else begin
                        check("r_drop_op", c.op, 0);
                        check("r_drop_full", store.size() == CAPACITY, 1);
                    end
                    if (!err_full || enq || deq) begin
                        outstanding = 1'b1; pend_op = c.op; pend_key = c.key;
                        timer = $urandom_range(1, 3);
                    end
                end
            end
            if (rsp_valid) begin
                if (!rsp_active) begin
                    rsp_active = 1'b1;
                    if (exp_rsp.size() > 0) begin
                        cur = exp_rsp.pop_front();
                    end else if (cmds.size() == 0) begin
                        check("r_unexpected_rsp", 1, 0);
                        cur = '{ONES, 1'b1};
                    end else begin
                        c = cmds.pop_front();
                        check("r_empty_op", c.op, 1);
                        check("r_empty_cnt", store.size(), 0);
                        cur = '{ONES, 1'b1};
                    end
                end
                check("r_rsp_key", rsp_key, cur.key);
                check("r_rsp_empty", rsp_empty, cur.empty);
            end
            ctl_done = 1'b0;
            if (outstanding) begin
                if (timer == 0) begin
                    ctl_done = 1'b1;
                    outstanding = 1'b0;
                    if (!pend_op) begin
                        store.push_back(pend_key);
                    end else if (store.size() > 0) begin
                        idx = 0;
                        for (int k = 1; k < store.size(); k++)
                            if (store[k] < store[idx]) idx = k;
                        ctl_key = store[idx];
                        store.delete(idx);
                        exp_rsp.push_back('{ctl_key, 1'b0});
                    end
                end else begin
                    timer--;
                end
            end
            gen = (cyc < 3600);
            req_valid = gen && ($urandom_range(0, 2) == 0);
            req_op = (cyc < 1800) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            req_key = 32'($urandom_range(0, 32'hFFFF));
            rsp_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (req_valid && req_ready) cmds.push_back('{req_op, req_key});
            if (rsp_valid && rsp_ready) rsp_active = 1'b0;
        end
        tick;
        check("r_drain_cmds", cmds.size(), 0);
        check("r_drain_rsp", exp_rsp.size(), 0);
        check("r_drain_outstanding", outstanding, 0);
        check("r_drain_rsp_valid", rsp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
